edge_event_counter: RTL and testbench

- Sequential sink placed directly downstream of the two-input OR whitebox cell. Its I input is driven by that cell's O.
- Counts rising edges of I and flags when a programmable threshold is reached.
- Provides a 4-phase snapshot/readout handshake so a consumer can sample the count without tearing.
- Modelled as a whitebox cell whose FASM feature set is IN_USE plus ENABLE_THRESHOLD. The THRESHOLD_EN parameter mirrors the ENABLE_THRESHOLD feature.

---
 rtl/edge_event_counter.sv | 107 ++++++++++
 tb/tb_edge_event_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_counter.sv
// Rising-edge event counter with saturation, registered threshold flag and a
// 4-phase snapshot handshake that lets a consumer read the count without tearing.
module edge_event_counter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned THRESHOLD    = 4,
  parameter bit          THRESHOLD_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             I,
  input  logic             EN,
  input  logic             CLR,
  input  logic             RD_REQ,
  output logic             RD_ACK,
  output logic [WIDTH-1:0] Q,
  output logic             O,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] CntMax    = '1;
  localparam logic [WIDTH-1:0] ThreshVal = WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             i_prev_q;
  logic             ack_q, ack_d;
  logic             o_q, o_d;
  logic             ovf_q, ovf_d;
  logic             evt;

  assign evt = I & ~i_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (CLR) begin
      // Clear wins over a coincident edge.
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (EN && evt) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    o_d = THRESHOLD_EN && (cnt_d >= ThreshVal);
  end

  // Snapshot takes the pre-update count, so a same-cycle edge or clear is excluded.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        if (RD_REQ) begin
          snap_d  = cnt_q;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!RD_REQ) begin
          ack_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StIdle;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      snap_q   <= '0;
      i_prev_q <= 1'b0;
      ack_q    <= 1'b0;
      o_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      i_prev_q <= I;
      ack_q    <= ack_d;
      o_q      <= o_d;
      ovf_q    <= ovf_d;
    end
  end

  assign RD_ACK = ack_q;
  assign Q      = snap_q;
  assign O      = o_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench: three counter variants (default, 4-bit, threshold disabled)
// share one stimulus stream; each scenario task checks its own expectations.
module tb_edge_event_counter;

  logic       clk = 1'b0;
  logic       rst_n, i_in, en, clr, rd_req;
  logic       ack_m, o_m, ovf_m;
  logic [7:0] q_m;
  logic       ack_s, o_s, ovf_s;
  logic [3:0] q_s;
  logic       ack_n, o_n, ovf_n;
  logic [7:0] q_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_event_counter u_main (
    .CLK(clk), .RST_N(rst_n), .I(i_in), .EN(en), .CLR(clr), .RD_REQ(rd_req),
    .RD_ACK(ack_m), .Q(q_m), .O(o_m), .OVF(ovf_m)
  );

  edge_event_counter #(.WIDTH(4)) u_sat (
    .CLK(clk), .RST_N(rst_n), .I(i_in), .EN(en), .CLR(clr), .RD_REQ(rd_req),
    .RD_ACK(ack_s), .Q(q_s), .O(o_s), .OVF(ovf_s)
  );

  edge_event_counter #(.THRESHOLD_EN(1'b0)) u_nothr (
    .CLK(clk), .RST_N(rst_n), .I(i_in), .EN(en), .CLR(clr), .RD_REQ(rd_req),
    .RD_ACK(ack_n), .Q(q_n), .O(o_n), .OVF(ovf_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    i_in = 1'b1;
    tick();
    i_in = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Full handshake; returns what was on the outputs while acknowledged.
  task automatic read_snap(output logic [7:0] qm, output logic [3:0] qs, output logic ack);
    rd_req = 1'b1;
    tick();
    ack = ack_m;
    qm  = q_m;
    qs  = q_s;
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] qm;
    logic [3:0] qs;
    logic       ack;
    rst_n = 1'b0; i_in = 1'b0; en = 1'b1; clr = 1'b0; rd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_in = ~i_in;
      tick();
    end
    n_checks++;
    if ({ack_m, q_m, o_m, ovf_m} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {ack_m, q_m, o_m, ovf_m});
    end
    i_in  = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) pulse();
    n_checks++;
    if (o_m !== 1'b0) begin n_fail++; $display("FAIL reset_o_after3: got %b required 0", o_m); end
    read_snap(qm, qs, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b required 1", ack); end
    n_checks++;
    if (qm !== 8'd3) begin n_fail++; $display("FAIL reset_cnt3: got %0d required 3", qm); end
    i_in = 1'b1;
    tick();
    n_checks++;
    if (o_m !== 1'b1) begin n_fail++; $display("FAIL reset_o_4th: got %b required 1", o_m); end
    i_in = 1'b0;
    tick();
  endtask

  task automatic test_level();
    logic [7:0] qm;
    logic [3:0] qs;
    logic       ack;
    en = 1'b1; i_in = 1'b1;
    repeat (10) tick();
    en = 1'b0; i_in = 1'b0;
    repeat (10) tick();
    pulse();
    read_snap(qm, qs, ack);
    n_checks++;
    if (qm !== 8'd5) begin n_fail++; $display("FAIL level_cnt: got %0d required 5", qm); end
    en = 1'b1;
  endtask

  task automatic test_saturation();
    logic [7:0] qm;
    logic [3:0] qs;
    logic       ack;
    do_clear();
    tick();
    n_checks++;
    if (o_m !== 1'b0) begin n_fail++; $display("FAIL sat_clr_o: got %b required 0", o_m); end
    for (int k = 0; k < 15; k++) pulse();
    read_snap(qm, qs, ack);
    n_checks++;
    if (qs !== 4'd15) begin n_fail++; $display("FAIL sat_cnt15: got %0d required 15", qs); end
    n_checks++;
    if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL sat_ovf15: got %b required 0", ovf_s); end
    pulse();
    n_checks++;
    if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL sat_ovf16: got %b required 1", ovf_s); end
    pulse();
    read_snap(qm, qs, ack);
    n_checks++;
    if (qs !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d required 15", qs); end
    n_checks++;
    if (qm !== 8'd17) begin n_fail++; $display("FAIL sat_main17: got %0d required 17", qm); end
    n_checks++;
    if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL sat_main_ovf: got %b required 0", ovf_m); end
    do_clear();
    n_checks++;
    if ({ovf_s, o_s, o_m} !== 3'b000) begin
      n_fail++;
      $display("FAIL sat_clear_flags: got %b required 000", {ovf_s, o_s, o_m});
    end
    read_snap(qm, qs, ack);
    n_checks++;
    if (qs !== 4'd0) begin n_fail++; $display("FAIL sat_clear_cnt: got %0d required 0", qs); end
  endtask

  task automatic test_handshake();
    for (int k = 0; k < 7; k++) pulse();
    rd_req = 1'b1;
    tick();
    n_checks++;
    if (ack_m !== 1'b1 || q_m !== 8'd7) begin
      n_fail++;
      $display("FAIL hs_capture: got ack=%b q=%0d required ack=1 q=7", ack_m, q_m);
    end
    pulse();
    pulse();
    n_checks++;
    if (ack_m !== 1'b1 || q_m !== 8'd7) begin
      n_fail++;
      $display("FAIL hs_frozen: got ack=%b q=%0d required ack=1 q=7", ack_m, q_m);
    end
    n_checks++;
    if (o_m !== 1'b1) begin n_fail++; $display("FAIL hs_o: got %b required 1", o_m); end
    rd_req = 1'b0;
    tick();
    n_checks++;
    if (ack_m !== 1'b0) begin n_fail++; $display("FAIL hs_ack_fall: got %b required 0", ack_m); end
    rd_req = 1'b1;
    tick();
    n_checks++;
    if (ack_m !== 1'b0) begin n_fail++; $display("FAIL hs_wait_guard: got %b required 0", ack_m); end
    tick();
    n_checks++;
    if (ack_m !== 1'b1 || q_m !== 8'd9) begin
      n_fail++;
      $display("FAIL hs_reread: got ack=%b q=%0d required ack=1 q=9", ack_m, q_m);
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_coincidence();
    logic [7:0] qm;
    logic [3:0] qs;
    logic       ack;
    do_clear();
    for (int k = 0; k < 5; k++) pulse();
    rd_req = 1'b1; clr = 1'b1; i_in = 1'b1;
    tick();
    n_checks++;
    if (ack_m !== 1'b1 || q_m !== 8'd5) begin
      n_fail++;
      $display("FAIL co_snapshot: got ack=%b q=%0d required ack=1 q=5", ack_m, q_m);
    end
    n_checks++;
    if (o_m !== 1'b0) begin n_fail++; $display("FAIL co_o: got %b required 0", o_m); end
    rd_req = 1'b0; clr = 1'b0; i_in = 1'b0;
    tick();
    tick();
    read_snap(qm, qs, ack);
    n_checks++;
    if (qm !== 8'd0) begin n_fail++; $display("FAIL co_dropped: got %0d required 0", qm); end
  endtask

  task automatic test_async_reset();
    logic [7:0] qm;
    logic [3:0] qs;
    logic       ack;
    for (int k = 0; k < 16; k++) pulse();
    rd_req = 1'b1;
    tick();
    n_checks++;
    if (ack_m !== 1'b1 || ovf_s !== 1'b1 || o_m !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got ack=%b ovf_s=%b o=%b required 1 1 1", ack_m, ovf_s, o_m);
    end
    #2;
    rst_n  = 1'b0;
    rd_req = 1'b0;
    #1;
    n_checks++;
    if ({ack_m, q_m, o_m, ovf_m, ack_s, q_s, ovf_s} !== 18'd0) begin
      n_fail++;
      $display("FAIL ar_immediate: got ack=%b q=%0d o=%b ovf_s=%b q_s=%0d required all 0",
               ack_m, q_m, o_m, ovf_s, q_s);
    end
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ack_m !== 1'b0) begin n_fail++; $display("FAIL ar_release_ack: got %b required 0", ack_m); end
    read_snap(qm, qs, ack);
    n_checks++;
    if (ack !== 1'b1 || qm !== 8'd0) begin
      n_fail++;
      $display("FAIL ar_idle_read: got ack=%b q=%0d required ack=1 q=0", ack, qm);
    end
  endtask

  task automatic test_threshold_en();
    int o_high = 0;
    do_clear();
    for (int k = 0; k < 20; k++) begin
      pulse();
      if (o_n !== 1'b0) o_high++;
    end
    n_checks++;
    if (o_high != 0) begin n_fail++; $display("FAIL thr_en_o: got %0d cycles high required 0", o_high); end
    n_checks++;
    if (o_m !== 1'b1) begin n_fail++; $display("FAIL thr_en_ref: got %b required 1", o_m); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_saturation();
    test_handshake();
    test_coincidence();
    test_async_reset();
    test_threshold_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
